service_rx: RTL
===============

SERVICE_RX -- requirements
Module: service_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data bits per serial frame.
REQ-002 SHALL have parameter DEPTH, default 4, meaning output FIFO entries (power of two, >=2).
REQ-003 SHALL have port wb_clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port wb_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_data  input  1  serial line from the core's o_data, idle high.
REQ-006 SHALL have port o_word  output  WIDTH  head-of-FIFO word.
REQ-007 SHALL have port o_valid  output  1  FIFO non-empty.
REQ-008 SHALL have port i_ready  input  1  consumer accepts o_word when o_valid&i_ready.
REQ-009 SHALL have port o_frame_err  output  1  sticky stop-bit error.
REQ-010 SHALL have port o_overflow  output  1  sticky dropped-word flag.
REQ-011 SHALL have port i_clr  input  1  clears sticky flags.

Function
REQ-012 SHALL sample i_data once per wb_clk; frame = start bit 0, WIDTH data bits LSB first, [parity], stop bit 1.
REQ-013 SHALL implement states IDLE, DATA, PARITY (only with SERVICE_RX_PARITY_EN), STOP.
REQ-014 IDLE: i_data=0 -> DATA with bit counter 0; i_data=1 -> stay IDLE.
REQ-015 DATA: shift i_data into bit counter position; after bit WIDTH-1 -> PARITY if enabled, else STOP.
REQ-016 STOP: i_data=1 and FIFO accepting -> push word; i_data=0 -> drop word, set o_frame_err; always -> IDLE.
REQ-017 A new start bit SHALL be recognised in the cycle immediately after STOP (back-to-back frames, WIDTH+2 cycles each).
REQ-018 Pushed word SHALL appear on o_word/o_valid the cycle after the stop bit is sampled when FIFO was empty.
REQ-019 FIFO accepting = not full, or full with pop (o_valid&i_ready) in the same cycle.
REQ-020 Push when not accepting SHALL drop the new word, keep FIFO contents, set o_overflow.
REQ-021 Pop SHALL advance read pointer; o_word SHALL hold stable while o_valid&!i_ready.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-023 Pointers SHALL wrap modulo DEPTH; full/empty via extra pointer MSB.
REQ-024 i_clr SHALL clear both flags; a same-cycle error event SHALL win (flag stays set).

Reset
REQ-025 wb_rst SHALL force IDLE, counter 0, FIFO empty, o_valid=0, o_word=0, o_frame_err=0, o_overflow=0.
REQ-026 Reset mid-frame SHALL discard the partial word; after release, reception restarts only on a new start bit.

Configuration
REQ-027 With SERVICE_RX_PARITY_EN defined: PARITY state samples one even-parity bit after data; mismatch drops word and sets o_frame_err; frame = WIDTH+3 cycles.
REQ-028 Without SERVICE_RX_PARITY_EN: no PARITY state or parity logic; frame = WIDTH+2 cycles.

Structure
REQ-029 SHALL place state enum (IDLE/DATA/PARITY/STOP) and default WIDTH/DEPTH constants in package service_rx_pkg.
REQ-030 SHALL implement FIFO as sub-module service_rx_fifo (push, pop, full, empty, head data); FSM and shifter in service_rx.

Verification
REQ-031 Single frame 0xDEADBEEF, i_ready=1 -> o_valid pulses 1 cycle, o_word=0xDEADBEEF, flags 0.
REQ-032 Four back-to-back frames 1,2,3,4 with i_ready=0, then fifth 5 -> FIFO holds 1..4, o_overflow=1; draining yields 1,2,3,4.
REQ-033 Frame 0x12345678 with stop bit 0 -> no push, o_frame_err=1; i_clr -> 0; next good frame received.
REQ-034 wb_rst asserted at data bit 10 of a frame -> all outputs 0; a following full frame 0xA5A5A5A5 received correctly.
REQ-035 FIFO full, i_ready=1 during STOP of frame 0x55 -> pop and push same cycle, no overflow, 0x55 delivered last.
REQ-036 With SERVICE_RX_PARITY_EN, frame 0x00000001 with parity bit 0 -> dropped, o_frame_err=1; parity 1 -> accepted.

Source files
------------

// File: rtl/service_rx_pkg.sv
// Shared types and default sizing for the service_rx serial receiver.
// ST_PARITY is only reachable when SERVICE_RX_PARITY_EN is defined.
package service_rx_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

endpackage

// File: rtl/service_rx_fifo.sv
// Output FIFO for received words: power-of-two depth, extra pointer MSB
// distinguishes full from empty. Head word reads as zero while empty.
module service_rx_fifo
    import service_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // Caller only pushes when full if a pop frees the head slot this cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge wb_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/service_rx.sv
// Serial frame receiver (start 0, WIDTH bits LSB first, stop 1) feeding a FIFO.
// Define SERVICE_RX_PARITY_EN to add an even-parity bit between data and stop.
module service_rx
    import service_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             i_data,
    output logic [WIDTH-1:0] o_word,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_frame_err,
    output logic             o_overflow,
    input  logic             i_clr
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    rx_state_t        r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_frame_err;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_accept;
    logic w_par_ok;
    logic w_push_req;
    logic w_push;
    logic w_err_evt;
    logic w_ovf_evt;

`ifdef SERVICE_RX_PARITY_EN
    logic r_par_ok;
    assign w_par_ok = r_par_ok;
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_pop      = !w_empty && i_ready;
    assign w_accept   = !w_full || w_pop;
    assign w_push_req = (r_state == ST_STOP) && i_data && w_par_ok;
    assign w_push     = w_push_req && w_accept;
    assign w_err_evt  = (r_state == ST_STOP) && (!i_data || !w_par_ok);
    assign w_ovf_evt  = w_push_req && !w_accept;

    assign o_valid     = !w_empty;
    assign o_frame_err = r_frame_err;
    assign o_overflow  = r_overflow;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
`ifdef SERVICE_RX_PARITY_EN
            r_par_ok    <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!i_data) begin
                        r_state <= ST_DATA;
                        r_cnt   <= '0;
                    end
                end
                ST_DATA: begin
                    r_shift[r_cnt] <= i_data;
                    if (r_cnt == CW'(WIDTH-1)) begin
                        r_cnt <= '0;
`ifdef SERVICE_RX_PARITY_EN
                        r_state <= ST_PARITY;
`else
                        r_state <= ST_STOP;
`endif
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`ifdef SERVICE_RX_PARITY_EN
                ST_PARITY: begin
                    // Even parity: the parity bit equals the XOR of the data bits.
                    r_par_ok <= ((^r_shift) == i_data);
                    r_state  <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Clear first so a same-cycle error event keeps its flag set.
            if (i_clr) begin
                r_frame_err <= 1'b0;
                r_overflow  <= 1'b0;
            end
            if (w_err_evt) begin
                r_frame_err <= 1'b1;
            end
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
        end
    end

    service_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .wb_clk  (wb_clk),
        .wb_rst  (wb_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (r_shift),
        .o_rdata (o_word),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
